// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Purpose : bundles the hazard controller's request inputs and its pipeline
//           control / status outputs into one connection.
// Signals :
//   stall_req     [NSTAGE]  per-stage hold request
//   flush_req     [NSTAGE]  per-stage clear request
//   md_start               mult/div issued this cycle
//   md_is_div              with md_start: 1=div, 0=mult
//   md_use                 consumer of HI/LO or md unit sits in MD_STAGE
//   pcen                   PC write enable
//   en            [NSTAGE]  pipeline register enables
//   clr           [NSTAGE]  pipeline register clears (bubble insert)
//   md_busy                mult/div busy timer nonzero
//   stall_cycles  [SCW]     saturating count of cycles with pcen=0
//   stall_timeout          sticky flag for an over-long consecutive stall
// Modports: master drives the requests (pipeline side / bench),
//           slave is the controller itself.
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int NSTAGE = 5,
    parameter int SCW    = 32
);
    logic [NSTAGE-1:0] stall_req;
    logic [NSTAGE-1:0] flush_req;
    logic              md_start;
    logic              md_is_div;
    logic              md_use;
    logic              pcen;
    logic [NSTAGE-1:0] en;
    logic [NSTAGE-1:0] clr;
    logic              md_busy;
    logic [SCW-1:0]    stall_cycles;
    logic              stall_timeout;

    modport master (
        output stall_req, flush_req, md_start, md_is_div, md_use,
        input  pcen, en, clr, md_busy, stall_cycles, stall_timeout
    );

    modport slave (
        input  stall_req, flush_req, md_start, md_is_div, md_use,
        output pcen, en, clr, md_busy, stall_cycles, stall_timeout
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Purpose : stall/flush controller for an NSTAGE pipeline. Merges per-stage
//           stall requests, flush requests and a mult/div busy timer into the
//           PC enable, per-stage register enables and bubble clears. Also
//           counts stall cycles and flags stalls that run too long.
// Ports   :
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    pipe_hazard_ctrl_if.slave (requests in, controls/status out)
// pcen/en/clr are combinational from the current requests and timer state;
// md_busy depends only on the registered timer.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int NSTAGE    = 5,
    parameter int MD_STAGE  = 1,
    parameter int MULT_CYC  = 5,
    parameter int DIV_CYC   = 10,
    parameter int CW        = 4,
    parameter int SCW       = 32,
    parameter int MAX_STALL = 64
) (
    input  logic             clk,
    input  logic             reset,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int IW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
    localparam int XW = $clog2(MAX_STALL + 1);

    logic [CW-1:0]     r_timer;
    logic [SCW-1:0]    r_stall_cycles;
    logic [XW-1:0]     r_consec;
    logic              r_timeout;

    logic              w_md_busy;
    logic              w_md_stall;
    logic [NSTAGE-1:0] w_req;
    logic              w_any;
    logic [IW-1:0]     w_top;
    logic              w_pcen;
    logic [NSTAGE-1:0] w_en;
    logic [NSTAGE-1:0] w_clr;

    assign w_md_busy = (r_timer != {CW{1'b0}});

    // Merge requests, find the deepest stalled stage, derive pcen/en/clr.
    always_comb begin
        w_md_stall = bus.md_use & (w_md_busy | bus.md_start);
        w_req      = bus.stall_req | (NSTAGE'(w_md_stall) << MD_STAGE);
        w_any      = 1'b0;
        w_top      = {IW{1'b0}};
        w_en       = {NSTAGE{1'b1}};
        w_clr      = bus.flush_req;
        // Ascending scan: the last set bit wins, giving the highest index.
        for (int i = 0; i < NSTAGE; i++) begin
            w_any = w_any | w_req[i];
            w_top = w_req[i] ? IW'(i) : w_top;
        end
        // Everything at or below the deepest stall holds; the stage just
        // after it receives a bubble so the held instruction is not duplicated.
        for (int i = 0; i < NSTAGE; i++) begin
            w_en[i]  = ~w_any | (i > int'(w_top));
            w_clr[i] = bus.flush_req[i] | (w_any & (i == int'(w_top) + 1));
        end
        w_pcen = ~w_any;
    end

    // Mult/div busy timer: loads only on an accepted start, else counts down.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= {CW{1'b0}};
        end else if (bus.md_start && w_pcen && !w_md_busy) begin
            r_timer <= bus.md_is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
        end else if (w_md_busy) begin
            r_timer <= r_timer - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_timer <= r_timer;
        end
    end

    // Stall statistics: total saturating count, consecutive run, sticky timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= {SCW{1'b0}};
            r_consec       <= {XW{1'b0}};
            r_timeout      <= 1'b0;
        end else if (!w_pcen) begin
            if (r_stall_cycles != {SCW{1'b1}}) begin
                r_stall_cycles <= r_stall_cycles + {{(SCW-1){1'b0}}, 1'b1};
            end else begin
                r_stall_cycles <= r_stall_cycles;
            end
            if (r_consec != XW'(MAX_STALL)) begin
                r_consec <= r_consec + {{(XW-1){1'b0}}, 1'b1};
            end else begin
                r_consec <= r_consec;
            end
            // This edge brings the run to MAX_STALL (or it is already there).
            if (r_consec >= XW'(MAX_STALL - 1)) begin
                r_timeout <= 1'b1;
            end else begin
                r_timeout <= r_timeout;
            end
        end else begin
            r_stall_cycles <= r_stall_cycles;
            r_consec       <= {XW{1'b0}};
            r_timeout      <= r_timeout;
        end
    end

    assign bus.pcen          = w_pcen;
    assign bus.en            = w_en;
    assign bus.clr           = w_clr;
    assign bus.md_busy       = w_md_busy;
    assign bus.stall_cycles  = r_stall_cycles;
    assign bus.stall_timeout = r_timeout;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Scenario tasks drive the controller; expected combinational outputs are
// pushed to a scoreboard queue as stimulus is applied and popped when the
// outputs are sampled. Registered status is checked after each rising edge.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
    typedef struct {
        logic       pcen;
        logic [4:0] en;
        logic [4:0] clr;
        logic       busy;
    } exp_t;

    logic  clk;
    logic  reset;
    int    checks;
    int    failures;
    int    exp_stall;
    exp_t  sb_q[$];
    exp_t  e;

    pipe_hazard_ctrl_if #(.NSTAGE(5), .SCW(32)) bus ();

    pipe_hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus at the falling edge.
    task automatic drive(input logic [4:0] sreq, input logic [4:0] freq,
                         input logic st, input logic dv, input logic use_i);
        @(negedge clk);
        bus.stall_req = sreq;
        bus.flush_req = freq;
        bus.md_start  = st;
        bus.md_is_div = dv;
        bus.md_use    = use_i;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0);
        #1;
        sb_q.push_back('{pcen: 1'b1, en: 5'b11111, clr: 5'b00000, busy: 1'b0});
        e = sb_q.pop_front();
        checks++;
        if ({bus.pcen, bus.en, bus.clr, bus.md_busy} !== {e.pcen, e.en, e.clr, e.busy}) begin
            failures++;
            $display("FAIL reset_comb got=%b_%b_%b_%b exp=%b_%b_%b_%b", bus.pcen, bus.en, bus.clr, bus.md_busy, e.pcen, e.en, e.clr, e.busy);
        end
        checks++;
        if (bus.stall_cycles !== 32'd0 || bus.stall_timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_status got=%0d/%b exp=0/0", bus.stall_cycles, bus.stall_timeout);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_stall = 0;
    endtask

    task automatic test_idle();
        for (int k = 0; k < 3; k++) begin
            drive(5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0);
            sb_q.push_back('{pcen: 1'b1, en: 5'b11111, clr: 5'b00000, busy: 1'b0});
            #1;
            e = sb_q.pop_front();
            checks++;
            if ({bus.pcen, bus.en, bus.clr, bus.md_busy} !== {e.pcen, e.en, e.clr, e.busy}) begin
                failures++;
                $display("FAIL idle_comb cyc=%0d got=%b_%b_%b_%b exp=%b_%b_%b_%b", k, bus.pcen, bus.en, bus.clr, bus.md_busy, e.pcen, e.en, e.clr, e.busy);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.stall_cycles !== 32'd0 || bus.stall_timeout !== 1'b0) begin
                failures++;
                $display("FAIL idle_status got=%0d/%b exp=0/0", bus.stall_cycles, bus.stall_timeout);
            end
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 4; k++) begin
            drive(5'b00010, 5'b00000, 1'b0, 1'b0, 1'b0);
            sb_q.push_back('{pcen: 1'b0, en: 5'b11100, clr: 5'b00100, busy: 1'b0});
            #1;
            e = sb_q.pop_front();
            checks++;
            if ({bus.pcen, bus.en, bus.clr, bus.md_busy} !== {e.pcen, e.en, e.clr, e.busy}) begin
                failures++;
                $display("FAIL stall_comb cyc=%0d got=%b_%b_%b_%b exp=%b_%b_%b_%b", k, bus.pcen, bus.en, bus.clr, bus.md_busy, e.pcen, e.en, e.clr, e.busy);
            end
            @(posedge clk); #1;
            exp_stall++;
            checks++;
            if (bus.stall_cycles !== 32'(exp_stall)) begin
                failures++;
                $display("FAIL stall_count got=%0d exp=%0d", bus.stall_cycles, exp_stall);
            end
        end
    endtask

    task automatic test_div();
        drive(5'b00000, 5'b00000, 1'b1, 1'b1, 1'b0);
        sb_q.push_back('{pcen: 1'b1, en: 5'b11111, clr: 5'b00000, busy: 1'b0});
        for (int k = 0; k < 11; k++) begin
            #1;
            e = sb_q.pop_front();
            checks++;
            if ({bus.pcen, bus.en, bus.clr, bus.md_busy} !== {e.pcen, e.en, e.clr, e.busy}) begin
                failures++;
                $display("FAIL div_comb cyc=%0d got=%b_%b_%b_%b exp=%b_%b_%b_%b", k, bus.pcen, bus.en, bus.clr, bus.md_busy, e.pcen, e.en, e.clr, e.busy);
            end
            @(posedge clk);
            if (!e.pcen) exp_stall++;
            drive(5'b00000, 5'b00000, 1'b0, 1'b0, 1'b1);
            if (k < 10)
                sb_q.push_back('{pcen: 1'b0, en: 5'b11100, clr: 5'b00100, busy: 1'b1});
            else
                sb_q.push_back('{pcen: 1'b1, en: 5'b11111, clr: 5'b00000, busy: 1'b0});
        end
        #1;
        e = sb_q.pop_front();
        checks++;
        if ({bus.pcen, bus.en, bus.clr, bus.md_busy} !== {e.pcen, e.en, e.clr, e.busy}) begin
            failures++;
            $display("FAIL div_release got=%b_%b_%b_%b exp=%b_%b_%b_%b", bus.pcen, bus.en, bus.clr, bus.md_busy, e.pcen, e.en, e.clr, e.busy);
        end
        checks++;
        if (bus.stall_cycles !== 32'(exp_stall)) begin
            failures++;
            $display("FAIL div_count got=%0d exp=%0d", bus.stall_cycles, exp_stall);
        end
    endtask

    task automatic test_back_to_back();
        // start and consumer in the same cycle: stall, start not accepted
        drive(5'b00000, 5'b00000, 1'b1, 1'b0, 1'b1);
        sb_q.push_back('{pcen: 1'b0, en: 5'b11100, clr: 5'b00100, busy: 1'b0});
        #1;
        e = sb_q.pop_front();
        checks++;
        if ({bus.pcen, bus.en, bus.clr, bus.md_busy} !== {e.pcen, e.en, e.clr, e.busy}) begin
            failures++;
            $display("FAIL b2b_comb got=%b_%b_%b_%b exp=%b_%b_%b_%b", bus.pcen, bus.en, bus.clr, bus.md_busy, e.pcen, e.en, e.clr, e.busy);
        end
        @(posedge clk); #1;
        exp_stall++;
        checks++;
        if (bus.md_busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ignored got=%b exp=0", bus.md_busy);
        end
        // mult start, then a div start while busy must be ignored (5 busy cycles)
        drive(5'b00000, 5'b00000, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            drive(5'b00000, 5'b00000, (k == 0), 1'b1, 1'b0);
            sb_q.push_back('{pcen: 1'b1, en: 5'b11111, clr: 5'b00000, busy: (k < 5)});
            #1;
            e = sb_q.pop_front();
            checks++;
            if ({bus.pcen, bus.en, bus.clr, bus.md_busy} !== {e.pcen, e.en, e.clr, e.busy}) begin
                failures++;
                $display("FAIL mult_busy cyc=%0d got=%b_%b_%b_%b exp=%b_%b_%b_%b", k, bus.pcen, bus.en, bus.clr, bus.md_busy, e.pcen, e.en, e.clr, e.busy);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_flush();
        logic [4:0] sreq_t [4] = '{5'b00001, 5'b01000, 5'b10000, 5'b00000};
        logic [4:0] freq_t [4] = '{5'b00001, 5'b10001, 5'b00110, 5'b01010};
        exp_t       exp_t4 [4] = '{
            '{pcen: 1'b0, en: 5'b11110, clr: 5'b00011, busy: 1'b0},
            '{pcen: 1'b0, en: 5'b10000, clr: 5'b10001, busy: 1'b0},
            '{pcen: 1'b0, en: 5'b00000, clr: 5'b00110, busy: 1'b0},
            '{pcen: 1'b1, en: 5'b11111, clr: 5'b01010, busy: 1'b0}};
        for (int k = 0; k < 4; k++) begin
            drive(sreq_t[k], freq_t[k], 1'b0, 1'b0, 1'b0);
            sb_q.push_back(exp_t4[k]);
            #1;
            e = sb_q.pop_front();
            checks++;
            if ({bus.pcen, bus.en, bus.clr, bus.md_busy} !== {e.pcen, e.en, e.clr, e.busy}) begin
                failures++;
                $display("FAIL flush_comb cyc=%0d got=%b_%b_%b_%b exp=%b_%b_%b_%b", k, bus.pcen, bus.en, bus.clr, bus.md_busy, e.pcen, e.en, e.clr, e.busy);
            end
            @(posedge clk);
            if (!e.pcen) exp_stall++;
        end
    endtask

    task automatic test_timeout();
        for (int n = 1; n <= 64; n++) begin
            drive(5'b00100, 5'b00000, 1'b0, 1'b0, 1'b0);
            sb_q.push_back('{pcen: 1'b0, en: 5'b11000, clr: 5'b01000, busy: 1'b0});
            #1;
            e = sb_q.pop_front();
            checks++;
            if ({bus.pcen, bus.en, bus.clr, bus.md_busy} !== {e.pcen, e.en, e.clr, e.busy}) begin
                failures++;
                $display("FAIL long_comb cyc=%0d got=%b_%b_%b_%b exp=%b_%b_%b_%b", n, bus.pcen, bus.en, bus.clr, bus.md_busy, e.pcen, e.en, e.clr, e.busy);
            end
            @(posedge clk); #1;
            exp_stall++;
            checks++;
            if (bus.stall_timeout !== (n >= 64)) begin
                failures++;
                $display("FAIL timeout_edge n=%0d got=%b exp=%b", n, bus.stall_timeout, (n >= 64));
            end
        end
        for (int k = 0; k < 3; k++) begin
            drive(5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
            checks++;
            if (bus.stall_timeout !== 1'b1 || bus.stall_cycles !== 32'(exp_stall)) begin
                failures++;
                $display("FAIL timeout_sticky got=%b/%0d exp=1/%0d", bus.stall_timeout, bus.stall_cycles, exp_stall);
            end
        end
    endtask

    task automatic test_reset_mid_mult();
        drive(5'b00000, 5'b00000, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            drive(5'b00000, 5'b00000, 1'b0, 1'b0, 1'b1);
            sb_q.push_back('{pcen: 1'b0, en: 5'b11100, clr: 5'b00100, busy: 1'b1});
            #1;
            e = sb_q.pop_front();
            checks++;
            if ({bus.pcen, bus.en, bus.clr, bus.md_busy} !== {e.pcen, e.en, e.clr, e.busy}) begin
                failures++;
                $display("FAIL mult_pre_reset cyc=%0d got=%b_%b_%b_%b exp=%b_%b_%b_%b", k, bus.pcen, bus.en, bus.clr, bus.md_busy, e.pcen, e.en, e.clr, e.busy);
            end
            @(posedge clk);
        end
        @(negedge clk);
        reset = 1'b1;
        sb_q.push_back('{pcen: 1'b1, en: 5'b11111, clr: 5'b00000, busy: 1'b0});
        #1;
        e = sb_q.pop_front();
        checks++;
        if ({bus.pcen, bus.en, bus.clr, bus.md_busy} !== {e.pcen, e.en, e.clr, e.busy}) begin
            failures++;
            $display("FAIL mid_reset_comb got=%b_%b_%b_%b exp=%b_%b_%b_%b", bus.pcen, bus.en, bus.clr, bus.md_busy, e.pcen, e.en, e.clr, e.busy);
        end
        checks++;
        if (bus.stall_cycles !== 32'd0 || bus.stall_timeout !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_status got=%0d/%b exp=0/0", bus.stall_cycles, bus.stall_timeout);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.md_use = 1'b0;
        exp_stall = 0;
        @(posedge clk); #1;
        checks++;
        if (bus.md_busy !== 1'b0 || bus.stall_cycles !== 32'd0) begin
            failures++;
            $display("FAIL post_reset got=%b/%0d exp=0/0", bus.md_busy, bus.stall_cycles);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_stall = 0;
        reset     = 1'b1;
        bus.stall_req = 5'b00000;
        bus.flush_req = 5'b00000;
        bus.md_start  = 1'b0;
        bus.md_is_div = 1'b0;
        bus.md_use    = 1'b0;
        test_reset();
        test_idle();
        test_stall();
        test_div();
        test_back_to_back();
        test_flush();
        test_timeout();
        test_reset_mid_mult();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
